// File: rtl/fpu_writeback.sv
// FPU writeback stage: one-entry WB register, 32 x 32-bit FPR file, FP condition code and sticky flags.
// Optional build macro FPU_WB_FWD_EN forwards the pending WB result onto the read ports.
module fpu_writeback #(
  parameter int unsigned NUM_FPR   = 32,
  parameter logic [31:0] RESET_FPR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_fd,
  input  logic [31:0] in_result,
  input  logic        in_fp_cc,
  input  logic        in_invalid,
  input  logic        in_overflow,
  input  logic        in_underflow,
  input  logic        mtc1_valid,
  output logic        mtc1_ready,
  input  logic [4:0]  mtc1_fd,
  input  logic [31:0] mtc1_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        fp_cc_q,
  output logic [2:0]  flags_q,
  input  logic        flags_clr,
  output logic        wb_busy
);

  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpCmpA = 4'b0011;
  localparam logic [3:0] OpCmpB = 4'b0100;
  localparam logic [3:0] OpCmpC = 4'b0101;
  localparam logic [3:0] OpMov  = 4'b0110;

  logic        wb_valid_q;
  logic [3:0]  wb_op_q;
  logic [4:0]  wb_fd_q;
  logic [31:0] wb_result_q;
  logic        wb_cc_q;
  logic [2:0]  wb_flags_q;

  logic [31:0] fpr_q [NUM_FPR];

  logic        accept;
  logic        commit;
  logic        wb_writes_fpr;
  logic        fp_cc_d;
  logic [2:0]  flags_d;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;

  assign in_ready      = !hold;
  assign accept        = in_valid && !hold;
  assign commit        = wb_valid_q && !hold;
  assign wb_writes_fpr = wb_valid_q &&
                         (wb_op_q == OpAdd || wb_op_q == OpSub || wb_op_q == OpMov);
  assign mtc1_ready    = !hold && !wb_writes_fpr;
  assign wb_busy       = wb_valid_q;

  always_comb begin
    fp_cc_d = fp_cc_q;
    flags_d = flags_q;
    if (commit) begin
      case (wb_op_q)
        OpAdd, OpSub:           flags_d = flags_q | wb_flags_q;
        OpCmpA, OpCmpB, OpCmpC: begin
          fp_cc_d    = wb_cc_q;
          flags_d[2] = flags_q[2] | wb_flags_q[2];
        end
        OpMov:                  flags_d = flags_q;
        default:                flags_d[2] = 1'b1;
      endcase
    end
    // Clear wins over a same-cycle commit; that entry's flags are dropped.
    if (flags_clr) flags_d = 3'b000;
  end

  // Single write port: an FPR-writing commit blocks mtc1 via mtc1_ready.
  always_comb begin
    fpr_we    = 1'b0;
    fpr_waddr = mtc1_fd;
    fpr_wdata = mtc1_data;
    if (commit && wb_writes_fpr) begin
      fpr_we    = 1'b1;
      fpr_waddr = wb_fd_q;
      fpr_wdata = wb_result_q;
    end else if (mtc1_valid && mtc1_ready) begin
      fpr_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_op_q     <= 4'b0000;
      wb_fd_q     <= 5'd0;
      wb_result_q <= 32'h0;
      wb_cc_q     <= 1'b0;
      wb_flags_q  <= 3'b000;
      fp_cc_q     <= 1'b0;
      flags_q     <= 3'b000;
      for (int i = 0; i < NUM_FPR; i++) fpr_q[i] <= RESET_FPR;
    end else begin
      fp_cc_q <= fp_cc_d;
      flags_q <= flags_d;
      if (accept) begin
        wb_valid_q  <= 1'b1;
        wb_op_q     <= in_op;
        wb_fd_q     <= in_fd;
        wb_result_q <= in_result;
        wb_cc_q     <= in_fp_cc;
        wb_flags_q  <= {in_invalid, in_overflow, in_underflow};
      end else if (commit) begin
        wb_valid_q <= 1'b0;
      end
      if (fpr_we) fpr_q[fpr_waddr] <= fpr_wdata;
    end
  end

`ifdef FPU_WB_FWD_EN
  assign rs_data = (wb_writes_fpr && rs_addr == wb_fd_q) ? wb_result_q : fpr_q[rs_addr];
  assign rt_data = (wb_writes_fpr && rt_addr == wb_fd_q) ? wb_result_q : fpr_q[rt_addr];
`else
  assign rs_data = fpr_q[rs_addr];
  assign rt_data = fpr_q[rt_addr];
`endif

endmodule
